// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: write-back arbiter in front of the register file write port.
// Port A (in-order pipeline) always wins. Port B (long-latency unit) results
// are buffered in a DEPTH-entry FIFO and retire in acceptance order. A newer
// port-A write kills queued port-B entries with the same destination register.
// Optional feature: define REGFILE_WB_STARVE_STALL_EN to build the starvation
// counter that drives o_stall_req. Without it, o_stall_req is tied to 0.
module regfile_wb_arb #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_a_valid,
  input  logic [4:0]  i_a_addr,
  input  logic [31:0] i_a_data,
  input  logic        i_b_valid,
  output logic        o_b_ready,
  input  logic [4:0]  i_b_addr,
  input  logic [31:0] i_b_data,
  output logic        o_wreg_en,
  output logic [4:0]  o_wreg_addr,
  output logic [31:0] o_wreg_data,
  output logic [31:0] o_pend_mask,
  output logic        o_stall_req
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [DEPTH-1:0] live_reg;
  logic [DEPTH-1:0] live_next;
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic a_win;
  logic fifo_empty;
  logic head_live;
  logic push;
  logic pop;
  logic kill_new;

  assign a_win      = i_a_valid && (i_a_addr != 5'd0);
  assign fifo_empty = (count_reg == '0);
  assign head_live  = !fifo_empty && live_reg[rd_ptr_reg];
  // Killed heads drain even while port A owns the write port.
  assign pop        = !fifo_empty && (!live_reg[rd_ptr_reg] || !a_win);
  // Readiness comes from registered occupancy only: no pop-through.
  assign o_b_ready  = !rst && (count_reg < DEPTH_C);
  // Address-0 results are accepted but never stored.
  assign push       = i_b_valid && o_b_ready && (i_b_addr != 5'd0);
  // A same-edge port-A write to the same register is newer than the B result.
  assign kill_new   = a_win && (i_b_addr == i_a_addr);

  // Per-entry live bit: set on enqueue, cleared on pop or on a port-A kill.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
      assign live_next[gi] =
          (push && (wr_ptr_reg == PW'(gi))) ? !kill_new :
          (pop  && (rd_ptr_reg == PW'(gi))) ? 1'b0 :
          (a_win && (addr_mem[gi] == i_a_addr)) ? 1'b0 :
          live_reg[gi];
    end
  endgenerate

  // FIFO pointers, occupancy and live bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      live_reg   <= '0;
    end else begin
      live_reg <= live_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  // FIFO payload storage; contents are meaningless while the live bit is 0.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= i_b_addr;
      data_mem[wr_ptr_reg] <= i_b_data;
    end
  end

  // Registered write port: port A first, then a live FIFO head, else idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_wreg_en   <= 1'b0;
      o_wreg_addr <= '0;
      o_wreg_data <= '0;
    end else if (a_win) begin
      o_wreg_en   <= 1'b1;
      o_wreg_addr <= i_a_addr;
      o_wreg_data <= i_a_data;
    end else if (head_live) begin
      o_wreg_en   <= 1'b1;
      o_wreg_addr <= addr_mem[rd_ptr_reg];
      o_wreg_data <= data_mem[rd_ptr_reg];
    end else begin
      o_wreg_en   <= 1'b0;
    end
  end

  // Pending-write mask: one-hot destination of every live entry.
  always_comb begin
    o_pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_reg[i]) o_pend_mask = o_pend_mask | (32'd1 << addr_mem[i]);
    end
  end

`ifdef REGFILE_WB_STARVE_STALL_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_cnt_reg;

  // Count cycles a live head is held off by port A; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst || fifo_empty || pop) begin
      starve_cnt_reg <= '0;
    end else if (head_live && (starve_cnt_reg < LIMIT_C)) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

  assign o_stall_req = (starve_cnt_reg >= LIMIT_C);
`else
  assign o_stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed testbench for regfile_wb_arb (DEPTH=4, STARVE_LIMIT=8).
module tb_regfile_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_a_valid;
  logic [4:0]  i_a_addr;
  logic [31:0] i_a_data;
  logic        i_b_valid;
  logic        o_b_ready;
  logic [4:0]  i_b_addr;
  logic [31:0] i_b_data;
  logic        o_wreg_en;
  logic [4:0]  o_wreg_addr;
  logic [31:0] o_wreg_data;
  logic [31:0] o_pend_mask;
  logic        o_stall_req;

  int errors = 0;
  int checks = 0;

  regfile_wb_arb #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .i_a_valid(i_a_valid), .i_a_addr(i_a_addr), .i_a_data(i_a_data),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready),
    .i_b_addr(i_b_addr), .i_b_data(i_b_data),
    .o_wreg_en(o_wreg_en), .o_wreg_addr(o_wreg_addr), .o_wreg_data(o_wreg_data),
    .o_pend_mask(o_pend_mask), .o_stall_req(o_stall_req)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_a_valid = 1'b0; i_a_addr = 5'd0; i_a_data = 32'd0;
    i_b_valid = 1'b0; i_b_addr = 5'd0; i_b_data = 32'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    i_b_valid = 1'b1; i_b_addr = 5'd6; i_b_data = 32'hDEAD;
    repeat (3) step();
    checks++; if (o_b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", o_b_ready); end
    checks++; if (o_wreg_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b want=0", o_wreg_en); end
    checks++; if (o_wreg_addr !== 5'd0 || o_wreg_data !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%0d/%h want=0/0", o_wreg_addr, o_wreg_data); end
    checks++; if (o_pend_mask !== 32'd0) begin errors++; $display("FAIL reset_pend got=%h want=0", o_pend_mask); end
    checks++; if (o_stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", o_stall_req); end
    rst = 1'b0;
    i_b_valid = 1'b0;
    step();
    checks++; if (o_b_ready !== 1'b1 || o_pend_mask !== 32'd0) begin errors++; $display("FAIL reset_release got=%b/%h want=1/0", o_b_ready, o_pend_mask); end
    step();
    checks++; if (o_wreg_en !== 1'b0) begin errors++; $display("FAIL reset_noenq got=%b want=0", o_wreg_en); end
    $display("test_reset: done");
  endtask

  task automatic test_port_a;
    i_a_valid = 1'b1; i_a_addr = 5'd5; i_a_data = 32'h1234;
    step();
    checks++; if (o_wreg_en !== 1'b1 || o_wreg_addr !== 5'd5 || o_wreg_data !== 32'h1234) begin errors++; $display("FAIL a_pass got=%b/%0d/%h want=1/5/1234", o_wreg_en, o_wreg_addr, o_wreg_data); end
    i_a_addr = 5'd0; i_a_data = 32'hFFFF;
    step();
    checks++; if (o_wreg_en !== 1'b0) begin errors++; $display("FAIL a_x0_en got=%b want=0", o_wreg_en); end
    checks++; if (o_wreg_addr !== 5'd5 || o_wreg_data !== 32'h1234) begin errors++; $display("FAIL a_x0_hold got=%0d/%h want=5/1234", o_wreg_addr, o_wreg_data); end
    idle_inputs();
    $display("test_port_a: done");
  endtask

  task automatic test_b_latency;
    i_b_valid = 1'b1; i_b_addr = 5'd7; i_b_data = 32'hAA;
    step();
    idle_inputs();
    checks++; if (o_wreg_en !== 1'b0 || o_pend_mask !== 32'h80) begin errors++; $display("FAIL b_lat1 got=%b/%h want=0/00000080", o_wreg_en, o_pend_mask); end
    step();
    checks++; if (o_wreg_en !== 1'b1 || o_wreg_addr !== 5'd7 || o_wreg_data !== 32'hAA) begin errors++; $display("FAIL b_lat2 got=%b/%0d/%h want=1/7/aa", o_wreg_en, o_wreg_addr, o_wreg_data); end
    checks++; if (o_pend_mask !== 32'd0) begin errors++; $display("FAIL b_lat_pend got=%h want=0", o_pend_mask); end
    step();
    checks++; if (o_wreg_en !== 1'b0) begin errors++; $display("FAIL b_lat3 got=%b want=0", o_wreg_en); end
    $display("test_b_latency: done");
  endtask

  task automatic test_backpressure;
    logic [4:0] exp_addr;
    i_a_valid = 1'b1; i_a_addr = 5'd1; i_a_data = 32'h100;
    for (int k = 0; k < 4; k++) begin
      i_b_valid = 1'b1; i_b_addr = 5'(10 + k); i_b_data = 32'hB0 + 32'(k);
      checks++; if (o_b_ready !== 1'b1) begin errors++; $display("FAIL bp_ready%0d got=%b want=1", k, o_b_ready); end
      step();
    end
    checks++; if (o_b_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%b want=0", o_b_ready); end
    checks++; if (o_pend_mask !== 32'h3C00) begin errors++; $display("FAIL bp_pend got=%h want=00003c00", o_pend_mask); end
    checks++; if (o_wreg_en !== 1'b1 || o_wreg_addr !== 5'd1) begin errors++; $display("FAIL bp_a_wins got=%b/%0d want=1/1", o_wreg_en, o_wreg_addr); end
    i_b_addr = 5'd14; i_b_data = 32'hEE;
    step();
    checks++; if (o_b_ready !== 1'b0 || o_pend_mask !== 32'h3C00) begin errors++; $display("FAIL bp_reject got=%b/%h want=0/00003c00", o_b_ready, o_pend_mask); end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      step();
      exp_addr = 5'(10 + k);
      checks++; if (o_wreg_en !== 1'b1 || o_wreg_addr !== exp_addr || o_wreg_data !== 32'hB0 + 32'(k)) begin errors++; $display("FAIL bp_drain%0d got=%b/%0d/%h want=1/%0d/%h", k, o_wreg_en, o_wreg_addr, o_wreg_data, exp_addr, 32'hB0 + 32'(k)); end
    end
    step();
    checks++; if (o_wreg_en !== 1'b0 || o_pend_mask !== 32'd0 || o_b_ready !== 1'b1) begin errors++; $display("FAIL bp_empty got=%b/%h/%b want=0/0/1", o_wreg_en, o_pend_mask, o_b_ready); end
    $display("test_backpressure: done");
  endtask

  task automatic test_kill;
    i_b_valid = 1'b1; i_b_addr = 5'd9; i_b_data = 32'h11;
    step();
    idle_inputs();
    checks++; if (o_pend_mask !== 32'h200) begin errors++; $display("FAIL kill_queued got=%h want=00000200", o_pend_mask); end
    i_a_valid = 1'b1; i_a_addr = 5'd9; i_a_data = 32'h22;
    step();
    idle_inputs();
    checks++; if (o_wreg_en !== 1'b1 || o_wreg_addr !== 5'd9 || o_wreg_data !== 32'h22) begin errors++; $display("FAIL kill_a got=%b/%0d/%h want=1/9/22", o_wreg_en, o_wreg_addr, o_wreg_data); end
    checks++; if (o_pend_mask !== 32'd0) begin errors++; $display("FAIL kill_pend got=%h want=0", o_pend_mask); end
    step();
    checks++; if (o_wreg_en !== 1'b0 || o_wreg_data !== 32'h22) begin errors++; $display("FAIL kill_pop got=%b/%h want=0/22", o_wreg_en, o_wreg_data); end
    i_a_valid = 1'b1; i_a_addr = 5'd3; i_a_data = 32'h33;
    i_b_valid = 1'b1; i_b_addr = 5'd3; i_b_data = 32'h44;
    step();
    idle_inputs();
    checks++; if (o_wreg_en !== 1'b1 || o_wreg_addr !== 5'd3 || o_wreg_data !== 32'h33) begin errors++; $display("FAIL kill_same got=%b/%0d/%h want=1/3/33", o_wreg_en, o_wreg_addr, o_wreg_data); end
    checks++; if (o_pend_mask !== 32'd0) begin errors++; $display("FAIL kill_same_pend got=%h want=0", o_pend_mask); end
    repeat (2) begin
      step();
      checks++; if (o_wreg_en !== 1'b0 || o_wreg_data !== 32'h33) begin errors++; $display("FAIL kill_same_nowr got=%b/%h want=0/33", o_wreg_en, o_wreg_data); end
    end
    $display("test_kill: done");
  endtask

  task automatic test_starve;
    logic exp_stall;
    i_b_valid = 1'b1; i_b_addr = 5'd4; i_b_data = 32'h4444;
    i_a_valid = 1'b1; i_a_addr = 5'd2; i_a_data = 32'h2;
    step();
    i_b_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
`ifdef REGFILE_WB_STARVE_STALL_EN
      exp_stall = (k >= 8);
`else
      exp_stall = 1'b0;
`endif
      checks++; if (o_stall_req !== exp_stall) begin errors++; $display("FAIL starve_cyc%0d got=%b want=%b", k, o_stall_req, exp_stall); end
    end
    idle_inputs();
    step();
    checks++; if (o_wreg_en !== 1'b1 || o_wreg_addr !== 5'd4 || o_wreg_data !== 32'h4444) begin errors++; $display("FAIL starve_drain got=%b/%0d/%h want=1/4/4444", o_wreg_en, o_wreg_addr, o_wreg_data); end
    checks++; if (o_stall_req !== 1'b0) begin errors++; $display("FAIL starve_clear got=%b want=0", o_stall_req); end
    $display("test_starve: done");
  endtask

  task automatic test_mid_reset;
    i_a_valid = 1'b1; i_a_addr = 5'd1; i_a_data = 32'h1;
    for (int k = 0; k < 3; k++) begin
      i_b_valid = 1'b1; i_b_addr = 5'(20 + k); i_b_data = 32'hC0 + 32'(k);
      step();
    end
    checks++; if (o_pend_mask !== 32'h0070_0000) begin errors++; $display("FAIL mrst_queued got=%h want=00700000", o_pend_mask); end
    idle_inputs();
    rst = 1'b1;
    step();
    checks++; if (o_wreg_en !== 1'b0 || o_pend_mask !== 32'd0 || o_b_ready !== 1'b0) begin errors++; $display("FAIL mrst_hold got=%b/%h/%b want=0/0/0", o_wreg_en, o_pend_mask, o_b_ready); end
    rst = 1'b0;
    repeat (3) begin
      step();
      checks++; if (o_wreg_en !== 1'b0 || o_pend_mask !== 32'd0 || o_b_ready !== 1'b1) begin errors++; $display("FAIL mrst_after got=%b/%h/%b want=0/0/1", o_wreg_en, o_pend_mask, o_b_ready); end
    end
    $display("test_mid_reset: done");
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_port_a();
    test_b_latency();
    test_backpressure();
    test_kill();
    test_starve();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
